// File: rtl/fb_write_stager.sv
// Queues CPU frame-buffer writes and replays each as a slow setup/strobe/gap sequence
// for the CPU->video synchronizer. Optional tail-entry coalescing: FB_STAGER_COALESCE_EN.
module fb_write_stager #(
  parameter int DEPTH          = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int WE_HIGH_CYCLES = 4,
  parameter int WE_LOW_CYCLES  = 4
) (
  input  logic                     clk_cpu_fast,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [11:0]              req_addr,
  input  logic [11:0]              req_data,
  output logic                     req_ready,
  output logic [11:0]              cpu_fb_addr,
  output logic [11:0]              cpu_fb_data,
  output logic                     cpu_fb_we,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int MAXC = (SETUP_CYCLES > WE_HIGH_CYCLES) ?
                        ((SETUP_CYCLES > WE_LOW_CYCLES) ? SETUP_CYCLES : WE_LOW_CYCLES) :
                        ((WE_HIGH_CYCLES > WE_LOW_CYCLES) ? WE_HIGH_CYCLES : WE_LOW_CYCLES);
  localparam int TW   = $clog2(MAXC);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP} state_t;

  logic [23:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [TW-1:0] tmr_q;
  logic [11:0]   addr_q, data_q;
  logic          we_q;

  logic push, push_enq, pop, coalesce;

  assign pop  = (state_q == S_IDLE) && (count_q != '0);
  assign push = req_valid && req_ready;

`ifdef FB_STAGER_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  logic          tail_hit;
  // The head may already be on its way out, so only a non-head tail is merged.
  assign tail_ptr  = wr_ptr_q - PW'(1);
  assign tail_hit  = (count_q >= CW'(2)) && (mem_q[tail_ptr][23:12] == req_addr);
  assign coalesce  = push && tail_hit;
  assign req_ready = (count_q < FULL) || tail_hit;
`else
  assign coalesce  = 1'b0;
  assign req_ready = (count_q < FULL);
`endif

  assign push_enq = push && !coalesce;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_enq && !pop)      count_d = count_q + CW'(1);
    else if (!push_enq && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_cpu_fast or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk_cpu_fast) begin
    if (push_enq) mem_q[wr_ptr_q] <= {req_addr, req_data};
`ifdef FB_STAGER_COALESCE_EN
    if (coalesce) mem_q[tail_ptr][11:0] <= req_data;
`endif
  end

  always_ff @(posedge clk_cpu_fast or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            addr_q  <= mem_q[rd_ptr_q][23:12];
            data_q  <= mem_q[rd_ptr_q][11:0];
            tmr_q   <= TW'(SETUP_CYCLES - 1);
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_q == '0) begin
            we_q    <= 1'b1;
            tmr_q   <= TW'(WE_HIGH_CYCLES - 1);
            state_q <= S_STROBE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_STROBE: begin
          if (tmr_q == '0) begin
            we_q    <= 1'b0;
            tmr_q   <= TW'(WE_LOW_CYCLES - 1);
            state_q <= S_GAP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_GAP: begin
          if (tmr_q == '0) state_q <= S_IDLE;
          else             tmr_q   <= tmr_q - TW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_fb_addr = addr_q;
  assign cpu_fb_data = data_q;
  assign cpu_fb_we   = we_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_fb_write_stager.sv
// Bench for fb_write_stager: directed scenarios plus random traffic, checked every cycle
// against a queue-and-timestamp reference model of the write sequencing.
module tb_fb_write_stager;

  localparam int DEPTH = 4;
  localparam int S = 2, H = 4, L = 4, T = S + H + L;
`ifdef FB_STAGER_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic [11:0] req_addr, req_data;
  logic        req_ready, cpu_fb_we, busy;
  logic [11:0] cpu_fb_addr, cpu_fb_data;
  logic [2:0]  fifo_count;

  fb_write_stager #(.DEPTH(DEPTH), .SETUP_CYCLES(S), .WE_HIGH_CYCLES(H), .WE_LOW_CYCLES(L)) dut (
    .clk_cpu_fast(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .cpu_fb_addr(cpu_fb_addr),
    .cpu_fb_data(cpu_fb_data), .cpu_fb_we(cpu_fb_we), .busy(busy), .fifo_count(fifo_count)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: pending entries in a queue, FSM timing from the last pop time.
  logic [23:0] mq[$];
  logic [23:0] m_cur = '0, m_t;
  int          cyc = 0, lp = 0, m_n;
  bit          lp_v = 1'b0, m_acc = 1'b0, m_a, m_c, m_p;
  bit          chk_en = 1'b0;

  function automatic bit m_ready(input logic [11:0] a);
    logic [23:0] t;
    if (mq.size() < DEPTH) return 1'b1;
    t = mq[mq.size()-1];
    return COAL && (t[23:12] == a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cur = '0;
      lp_v  = 1'b0;
      m_acc = 1'b0;
    end else begin
      cyc++;
      m_n = mq.size();
      m_a = req_valid && m_ready(req_addr);
      m_c = 1'b0;
      if (COAL && m_a && m_n >= 2) begin
        m_t = mq[m_n-1];
        m_c = (m_t[23:12] == req_addr);
      end
      m_p = (m_n > 0) && (!lp_v || cyc > lp + T);
      if (m_p) begin
        m_cur = mq.pop_front();
        lp    = cyc;
        lp_v  = 1'b1;
      end
      if (m_a) begin
        if (m_c) begin
          m_t = mq[mq.size()-1];
          m_t[11:0] = req_data;
          mq[mq.size()-1] = m_t;
        end else begin
          mq.push_back({req_addr, req_data});
        end
      end
      m_acc = m_a;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fifo_count", fifo_count, mq.size());
      chk("req_ready", req_ready, m_ready(req_addr));
      chk("we", cpu_fb_we, lp_v && cyc >= lp + S && cyc < lp + S + H);
      chk("addr", cpu_fb_addr, m_cur[23:12]);
      chk("data", cpu_fb_data, m_cur[11:0]);
      chk("busy", busy, (mq.size() != 0) || (lp_v && cyc < lp + T));
    end
  end

  int          rises[$];
  logic [11:0] rise_dat[$];
  bit          we_prev = 1'b0;
  always @(negedge clk) begin
    if (cpu_fb_we === 1'b1 && !we_prev) begin
      rises.push_back(cyc);
      rise_dat.push_back(cpu_fb_data);
    end
    we_prev = (cpu_fb_we === 1'b1);
  end

  bit saw_full = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] a, input logic [11:0] d);
    int w = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    do begin
      if (fifo_count == 3'(DEPTH) && !req_ready) saw_full = 1'b1;
      step();
      w++;
    end while (!m_acc && w < 200);
    if (!m_acc) chk("push_timeout", w, 0);
  endtask

  task automatic wait_idle();
    int w = 0;
    req_valid = 1'b0;
    while (busy !== 1'b0 && w < 300) begin
      step();
      w++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int hi, first;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) step();
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_we", cpu_fb_we, 0);
    chk("rst_addr", cpu_fb_addr, 0);
    chk("rst_busy", busy, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Single write: load after 1 cycle, strobe 4 cycles from +3, idle at +11.
    req_valid = 1'b1; req_addr = 12'h123; req_data = 12'hABC;
    step();
    req_valid = 1'b0;
    chk("t34_acc_count", fifo_count, 1);
    chk("t34_not_loaded", cpu_fb_addr, 0);
    step();
    chk("t34_addr", cpu_fb_addr, 12'h123);
    chk("t34_data", cpu_fb_data, 12'hABC);
    step();
    chk("t34_setup_we", cpu_fb_we, 0);
    hi = 0; first = -1;
    for (int i = 3; i <= 11; i++) begin
      step();
      if (cpu_fb_we) begin
        hi++;
        if (first < 0) first = i;
      end
      if (i == 10) chk("t34_busy_gap", busy, 1);
      if (i == 11) chk("t34_idle", busy, 0);
    end
    chk("t34_we_cycles", hi, 4);
    chk("t34_we_start", first, 3);

    // Burst of 6 back-to-back.
    rises.delete(); rise_dat.delete();
    for (int i = 0; i < 6; i++) push(12'h200 + 12'(i), 12'h800 + 12'(3 * i));
    wait_idle();
    chk("t35_saw_full", saw_full, 1);
    chk("t35_writes", rises.size(), 6);
    for (int i = 1; i < rises.size(); i++) chk("t35_period", rises[i] - rises[i-1], 11);
    for (int i = 0; i < rise_dat.size(); i++) chk("t35_order", rise_dat[i], 12'h800 + 12'(3 * i));

    // Push and pop on the same edge with two entries queued.
    push(12'h300, 12'h001); push(12'h301, 12'h002); push(12'h302, 12'h003);
    req_valid = 1'b0;
    repeat (9) step();
    push(12'h303, 12'h004);
    chk("t38_pushpop", fifo_count, 2);
    wait_idle();
    rises.delete(); rise_dat.delete();
    for (int i = 0; i < 2 * DEPTH + 1; i++) push(12'h310 + 12'(i), 12'h0F0 ^ 12'(i));
    wait_idle();
    chk("t38_wrap_writes", rises.size(), 2 * DEPTH + 1);
    if (rise_dat.size() > 0) chk("t38_wrap_last", rise_dat[rise_dat.size()-1], 12'h0F0 ^ 12'(2 * DEPTH));

    // Tail coalescing behind an in-flight write.
    rises.delete(); rise_dat.delete();
    push(12'h030, 12'h0A0); push(12'h010, 12'h111); push(12'h020, 12'h222); push(12'h020, 12'h555);
    req_valid = 1'b0;
    chk("t37_count", fifo_count, COAL ? 2 : 3);
    wait_idle();
    chk("t37_strobes", rises.size(), COAL ? 3 : 4);
    if (rise_dat.size() > 0) chk("t37_last_data", rise_dat[rise_dat.size()-1], 12'h555);
    push(12'h010, 12'h111); push(12'h020, 12'h222); push(12'h020, 12'h555);
    req_valid = 1'b0;
    chk("t37_empty_nocoal", fifo_count, 2);
    wait_idle();

    // Reset in the 2nd strobe cycle with 3 entries queued.
    for (int i = 0; i < 4; i++) push(12'h400 + 12'(i), 12'h444 + 12'(i));
    req_valid = 1'b0;
    hi = 0;
    while (cpu_fb_we !== 1'b1 && hi < 20) begin step(); hi++; end
    chk("t36_strobe_seen", cpu_fb_we, 1);
    chk("t36_queued", fifo_count, 3);
    step();
    #2 rst = 1'b1;
    #1;
    chk("t36_we_async", cpu_fb_we, 0);
    chk("t36_count", fifo_count, 0);
    chk("t36_addr", cpu_fb_addr, 0);
    chk("t36_ready", req_ready, 1);
    rises.delete();
    step(); step();
    rst = 1'b0;
    repeat (30) step();
    chk("t36_no_strobe", rises.size(), 0);
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 1'b1; req_addr = 12'h5A5; req_data = 12'h3C3;
    step();
    chk("t32_first_push", fifo_count, 1);
    wait_idle();

    // Random traffic from a small address set; the source holds unaccepted requests.
    for (int i = 0; i < 3000; i++) begin
      if (!req_valid || m_acc) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_addr  = 12'h100 + 12'($urandom_range(0, 3));
        req_data  = 12'($urandom);
      end
      step();
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
